muxpga_cfg_loader: RTL and testbench

//  Framed bitstream loader sitting directly upstream of the muxpga fabric. Accepts a nibble stream

---
 rtl/muxpga_cfg_loader.sv | 188 ++++++++++++++++++
 tb/tb_muxpga_cfg_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muxpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// muxpga_cfg_loader
//
// Framed bitstream loader that sits in front of the muxpga fabric. It takes a
// nibble stream with a valid/ready handshake and looks for a two-nibble sync
// word. It then collects NIBBLES payload nibbles into a shadow buffer and
// compares a 4-bit additive checksum. When a frame checks good, the payload is
// replayed into the fabric config shift chain (fab_cmd=0), one nibble per clock.
// After that the fabric is handed back to run/hold control.
//
// Ports
//   clk         in   1  clock
//   reset       in   1  synchronous, active-high reset
//   in_valid    in   1  in_nibble valid
//   in_nibble   in   4  stream nibble
//   in_ready    out  1  loader accepts in_nibble this cycle
//   run_en      in   1  request fabric evaluate once configured
//   fab_nibble  out  4  to fabric nibble_in (0 outside the shift phase)
//   fab_cmd     out  2  fabric command: 0 shift cfg, 1 run, 2 hold
//   busy        out  1  frame in progress (not hunting)
//   cfg_done    out  1  fabric holds a complete, checksum-verified config
//   crc_err     out  1  sticky: last completed frame failed its checksum
// -----------------------------------------------------------------------------
module muxpga_cfg_loader #(
  parameter int          NIBBLES = 24,
  parameter logic [3:0]  SYNC_A  = 4'hA,
  parameter logic [3:0]  SYNC_B  = 4'h5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_nibble,
  output logic       in_ready,
  input  logic       run_en,
  output logic [3:0] fab_nibble,
  output logic [1:0] fab_cmd,
  output logic       busy,
  output logic       cfg_done,
  output logic       crc_err
);

  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] CMD_SHIFT = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_HOLD  = 2'd2;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    SYNC  = 3'd1,
    LOAD  = 3'd2,
    CHK   = 3'd3,
    SHIFT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sum_q, sum_d;
  logic             cfg_done_q, cfg_done_d;
  logic             crc_err_q, crc_err_d;

  // Shadow payload buffer: data only, deliberately left out of reset.
  logic [3:0]       buf_q [NIBBLES];
  logic             buf_we;

  logic             xfer;

  // The handshake uses the registered state only, so in_ready has no
  // combinational path from in_valid.
  assign in_ready = (state_q != SHIFT);
  assign xfer     = in_valid & in_ready;

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      sum_q      <= '0;
      cfg_done_q <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      cfg_done_q <= cfg_done_d;
      crc_err_q  <= crc_err_d;
    end
  end

  // Payload capture
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[cnt_q] <= in_nibble;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    cfg_done_d = cfg_done_q;
    crc_err_d  = crc_err_q;
    buf_we     = 1'b0;

    case (state_q)
      HUNT: begin
        if (xfer && in_nibble == SYNC_A) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (xfer) begin
          if (in_nibble == SYNC_B) begin
            state_d = LOAD;
            cnt_d   = '0;
            sum_d   = '0;
          end else if (in_nibble != SYNC_A) begin
            state_d = HUNT;
          end
          // A repeated SYNC_A keeps us waiting for SYNC_B.
        end
      end

      LOAD: begin
        // Payload is opaque: sync nibbles are not interpreted here.
        if (xfer) begin
          buf_we = 1'b1;
          sum_d  = sum_q + in_nibble;
          if (cnt_q == CNT_LAST) begin
            state_d = CHK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      CHK: begin
        if (xfer) begin
          if (in_nibble == sum_q) begin
            // The old config is about to be overwritten, so cfg_done drops now.
            state_d    = SHIFT;
            cnt_d      = '0;
            crc_err_d  = 1'b0;
            cfg_done_d = 1'b0;
          end else begin
            // A bad frame leaves the fabric and cfg_done as they were.
            state_d   = HUNT;
            crc_err_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = HUNT;
          cnt_d      = '0;
          cfg_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs: run_en only chooses between run and hold once the loader
  // is not driving the chain.
  always_comb begin
    fab_nibble = 4'd0;
    fab_cmd    = (cfg_done_q && run_en) ? CMD_RUN : CMD_HOLD;
    if (state_q == SHIFT) begin
      fab_nibble = buf_q[cnt_q];
      fab_cmd    = CMD_SHIFT;
    end
  end

  assign busy     = (state_q != HUNT);
  assign cfg_done = cfg_done_q;
  assign crc_err  = crc_err_q;

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
module tb_muxpga_cfg_loader;

  localparam int N = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_nibble;
  logic       in_ready;
  logic       run_en;
  logic [3:0] fab_nibble;
  logic [1:0] fab_cmd;
  logic       busy;
  logic       cfg_done;
  logic       crc_err;

  muxpga_cfg_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_nibble  (in_nibble),
    .in_ready   (in_ready),
    .run_en     (run_en),
    .fab_nibble (fab_nibble),
    .fab_cmd    (fab_cmd),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .crc_err    (crc_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame-level view of the stream.
  // ph: 0 hunting, 1 seen first sync, 2 collecting payload, 3 awaiting checksum.
  int         ph = 0;
  logic [3:0] pay[$];
  logic [3:0] shq[$];   // nibbles still to be shifted into the fabric
  bit         m_cfg = 0;
  bit         m_err = 0;
  logic [3:0] shlog[$]; // nibbles the DUT actually shifted out

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sum16(input logic [3:0] q[$]);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    return 4'(s % 16);
  endfunction

  task automatic step(input bit do_cmp);
    logic [1:0] e_cmd;
    @(negedge clk);
    if (do_cmp) begin
      e_cmd = (shq.size() != 0) ? 2'd0 : ((m_cfg && run_en) ? 2'd1 : 2'd2);
      cmp("fab_cmd",    fab_cmd,    e_cmd);
      cmp("fab_nibble", fab_nibble, (shq.size() != 0) ? shq[0] : 4'd0);
      cmp("in_ready",   in_ready,   shq.size() == 0);
      cmp("busy",       busy,       (ph != 0) || (shq.size() != 0));
      cmp("cfg_done",   cfg_done,   m_cfg);
      cmp("crc_err",    crc_err,    m_err);
    end
    if (fab_cmd == 2'd0) shlog.push_back(fab_nibble);
    @(posedge clk);
    if (reset) begin
      ph = 0; pay.delete(); shq.delete(); m_cfg = 0; m_err = 0;
    end else if (shq.size() != 0) begin
      void'(shq.pop_front());
      if (shq.size() == 0) m_cfg = 1;
    end else if (in_valid) begin
      case (ph)
        0: if (in_nibble == 4'hA) ph = 1;
        1: begin
          if (in_nibble == 4'h5) begin ph = 2; pay.delete(); end
          else if (in_nibble != 4'hA) ph = 0;
        end
        2: begin
          pay.push_back(in_nibble);
          if (pay.size() == N) ph = 3;
        end
        default: begin
          if (in_nibble == sum16(pay)) begin
            shq = pay; m_err = 0; m_cfg = 0;
          end else begin
            m_err = 1;
          end
          ph = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic send(input logic [3:0] nib, input bit gaps);
    int  guard = 0;
    bit  xfer;
    forever begin
      in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_nibble = in_valid ? nib : 4'($urandom);
      xfer = in_valid && (shq.size() == 0);
      step(1);
      if (xfer) break;
      guard++;
      if (guard > 200) begin
        cmp("send_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] p[$], input logic [3:0] c, input bit gaps);
    send(4'hA, gaps);
    send(4'h5, gaps);
    foreach (p[i]) send(p[i], gaps);
    send(c, gaps);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (shq.size() != 0) begin
      step(1);
      guard++;
      if (guard > 100) begin
        cmp("shift_timeout", 1, 0);
        break;
      end
    end
    step(1);
  endtask

  task automatic check_shlog(input string tag, input logic [3:0] p[$]);
    cmp({tag, "_len"}, shlog.size(), p.size());
    if (shlog.size() == p.size())
      foreach (p[i]) cmp({tag, "_nib"}, shlog[i], p[i]);
  endtask

  logic [3:0] base[$];
  logic [3:0] rp[$];
  logic [3:0] c;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_nibble = 4'd0; run_en = 1'b0;
    for (int k = 0; k < N; k++) base.push_back(4'(k % 16));

    // 1: reset
    step(0);
    step(0);
    reset = 1'b0;
    cmp("rst_fab_cmd", fab_cmd, 2'd2);
    cmp("rst_fab_nibble", fab_nibble, 4'd0);
    cmp("rst_in_ready", in_ready, 1'b1);
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_cfg_done", cfg_done, 1'b0);
    cmp("rst_crc_err", crc_err, 1'b0);
    step(1);

    // 2: good frame, checksum 4
    cmp("chk_sum_const", sum16(base), 4'h4);
    shlog.delete();
    send_frame(base, 4'h4, 0);
    wait_idle();
    check_shlog("t2_shift", base);
    cmp("t2_cfg_done", cfg_done, 1'b1);
    run_en = 1'b1;
    step(1);
    cmp("t2_run", fab_cmd, 2'd1);

    // 3: bad checksum
    shlog.delete();
    send_frame(base, 4'h5, 0);
    step(1); step(1);
    cmp("t3_no_shift", shlog.size(), 0);
    cmp("t3_crc_err", crc_err, 1'b1);
    cmp("t3_cfg_kept", cfg_done, 1'b1);
    cmp("t3_busy", busy, 1'b0);

    // 4: sync hunting and stalls
    run_en = 1'b0;
    send(4'hA, 0);
    cmp("t4_a_busy", busy, 1'b1);
    send(4'h3, 0);
    cmp("t4_a3_hunt", busy, 1'b0);
    shlog.delete();
    send(4'hA, 1);
    send(4'hA, 1);
    send(4'h5, 1);
    foreach (base[i]) send(base[i], 1);
    send(4'h4, 1);
    wait_idle();
    check_shlog("t4_shift", base);

    // 5: reset during the 10th shift cycle
    send_frame(base, 4'h4, 0);
    for (int i = 0; i < 9; i++) step(1);
    cmp("t5_in_shift", fab_cmd, 2'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cmp("t5_fab_cmd", fab_cmd, 2'd2);
    cmp("t5_cfg_done", cfg_done, 1'b0);
    cmp("t5_busy", busy, 1'b0);
    rp.delete();
    for (int i = 0; i < N; i++) rp.push_back(4'($urandom));
    shlog.delete();
    send_frame(rp, sum16(rp), 1);
    wait_idle();
    check_shlog("t5_shift", rp);
    cmp("t5_reload", cfg_done, 1'b1);

    // 6: reconfigure while running, after a failed frame
    run_en = 1'b1;
    send_frame(rp, sum16(rp) + 4'd1, 0);
    cmp("t6_err_set", crc_err, 1'b1);
    rp.delete();
    for (int i = 0; i < N; i++) rp.push_back(4'($urandom));
    send(4'hA, 0);
    send(4'h5, 0);
    cmp("t6_run_load", fab_cmd, 2'd1);
    foreach (rp[i]) send(rp[i], 1);
    cmp("t6_run_chk", fab_cmd, 2'd1);
    shlog.delete();
    send(sum16(rp), 0);
    cmp("t6_cfg_drop", cfg_done, 1'b0);
    wait_idle();
    check_shlog("t6_shift", rp);
    cmp("t6_cfg_done", cfg_done, 1'b1);
    cmp("t6_run", fab_cmd, 2'd1);
    cmp("t6_err_clr", crc_err, 1'b0);

    // Random frames with junk between them; the model checks every cycle.
    for (int f = 0; f < 8; f++) begin
      run_en = 1'($urandom);
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) send(4'($urandom_range(0, 9)), 1);
      send(4'h3, 0);
      rp.delete();
      for (int i = 0; i < N; i++) rp.push_back(4'($urandom));
      c = sum16(rp);
      if ($urandom_range(0, 2) == 0) c = c + 4'($urandom_range(1, 15));
      send_frame(rp, c, 1'($urandom));
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
